// File: rtl/tl_release_sink_pkg.sv
// Shared TileLink C/D channel definitions for the release sink: opcodes, line geometry
// and the captured C-channel header.
package tl_release_sink_pkg;

  localparam int TL_ADDR_W     = 32;
  localparam int TL_SRC_W      = 3;
  localparam int TL_BEAT_W     = 128;
  localparam int TL_BEATS      = 4;
  localparam int TL_LINE_BYTES = 64;
  localparam int TL_OFFSET_W   = $clog2(TL_LINE_BYTES);

  typedef enum logic [2:0] {
    TL_C_PROBE_ACK      = 3'd4,
    TL_C_PROBE_ACK_DATA = 3'd5,
    TL_C_RELEASE        = 3'd6,
    TL_C_RELEASE_DATA   = 3'd7
  } tl_c_opcode_e;

  typedef enum logic [2:0] {
    TL_D_RELEASE_ACK = 3'd6
  } tl_d_opcode_e;

  typedef struct packed {
    logic [2:0]           param;
    logic [3:0]           size;
    logic [TL_SRC_W-1:0]  source;
    logic [TL_ADDR_W-1:0] address;
  } tl_c_hdr_t;

  function automatic logic is_c_data(input logic [2:0] op);
    return (op == TL_C_PROBE_ACK_DATA) || (op == TL_C_RELEASE_DATA);
  endfunction

endpackage

// File: rtl/tl_release_sink_line_buffer.sv
// One cache line of beat registers: indexed beat write port, flat line read port with
// beat 0 in the least significant bits.
module tl_release_sink_line_buffer #(
  parameter int BEAT_W = 128,
  parameter int BEATS  = 4
) (
  input  logic                       clock,
  input  logic                       i_wr_en,
  input  logic [$clog2(BEATS)-1:0]   i_wr_idx,
  input  logic [BEAT_W-1:0]          i_wr_data,
  output logic [BEAT_W*BEATS-1:0]    o_line
);

  // Contents are only meaningful once all beats of a message have landed, so no reset.
  logic [BEATS-1:0][BEAT_W-1:0] r_beats;

  always_ff @(posedge clock) begin
    if (i_wr_en) begin
      r_beats[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_line = r_beats;

endmodule

// File: rtl/tl_release_sink.sv
// Manager-side TileLink C-channel sink: collects Release/ProbeAck messages, writes dirty
// lines to the backing store, then answers with ReleaseAck on D or a probe-ack pulse.
module tl_release_sink
  import tl_release_sink_pkg::*;
#(
  parameter int ADDR_W = TL_ADDR_W,
  parameter int SRC_W  = TL_SRC_W,
  parameter int BEAT_W = TL_BEAT_W,
  parameter int BEATS  = TL_BEATS
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      c_valid,
  output logic                      c_ready,
  input  logic [2:0]                c_opcode,
  input  logic [2:0]                c_param,
  input  logic [3:0]                c_size,
  input  logic [SRC_W-1:0]          c_source,
  input  logic [ADDR_W-1:0]         c_address,
  input  logic [BEAT_W-1:0]         c_data,
  output logic                      mem_wr_valid,
  input  logic                      mem_wr_ready,
  output logic [ADDR_W-1:0]         mem_wr_addr,
  output logic [BEAT_W*BEATS-1:0]   mem_wr_data,
  output logic                      d_valid,
  input  logic                      d_ready,
  output logic [2:0]                d_opcode,
  output logic [2:0]                d_param,
  output logic [3:0]                d_size,
  output logic [SRC_W-1:0]          d_source,
  output logic                      probe_ack_valid,
  output logic [2:0]                probe_ack_param,
  output logic [SRC_W-1:0]          probe_ack_source,
  output logic                      probe_ack_dirty,
  output logic                      proto_err,
  output logic [2:0]                o_dbg_state
);

  localparam int                CNT_W     = $clog2(BEATS);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COLLECT   = 3'd1,
    S_MEM_WRITE = 3'd2,
    S_ACK       = 3'd3,
    S_NOTIFY    = 3'd4
  } state_e;

  state_e           r_state;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [2:0]       r_opcode;
  tl_c_hdr_t        r_hdr;
  logic             r_proto_err;
  logic             r_mem_wr_valid;
  logic             r_d_valid;
  logic             r_probe_ack_valid;

  logic             w_c_fire;
  logic             w_hdr_fire;
  logic             w_collect_fire;
  logic             w_hdr_misaligned;
  logic             w_beat_mismatch;
  logic             w_buf_wr_en;
  logic [CNT_W-1:0] w_buf_idx;
  tl_c_hdr_t        w_c_hdr;
  logic [BEAT_W*BEATS-1:0] w_line;

  // Handshakes: a beat/line/response transfers on a posedge where valid && ready are both
  // high; once raised, mem_wr_valid and d_valid hold with stable payload until that edge.
  assign c_ready        = !reset && ((r_state == S_IDLE) || (r_state == S_COLLECT));
  assign w_c_fire       = c_valid && c_ready;
  assign w_hdr_fire     = w_c_fire && (r_state == S_IDLE);
  assign w_collect_fire = w_c_fire && (r_state == S_COLLECT);

  assign w_c_hdr = '{param: c_param, size: c_size, source: c_source, address: c_address};
  assign w_hdr_misaligned = |c_address[TL_OFFSET_W-1:0];
  assign w_beat_mismatch  = (c_opcode != r_opcode) || (c_source != r_hdr.source) ||
                            (c_address != r_hdr.address);

  assign w_buf_wr_en = (w_hdr_fire && is_c_data(c_opcode)) || w_collect_fire;
  assign w_buf_idx   = (r_state == S_COLLECT) ? r_beat_cnt : '0;

  tl_release_sink_line_buffer #(
    .BEAT_W (BEAT_W),
    .BEATS  (BEATS)
  ) u_line_buf (
    .clock     (clock),
    .i_wr_en   (w_buf_wr_en),
    .i_wr_idx  (w_buf_idx),
    .i_wr_data (c_data),
    .o_line    (w_line)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state           <= S_IDLE;
      r_beat_cnt        <= '0;
      r_opcode          <= '0;
      r_hdr             <= '0;
      r_proto_err       <= 1'b0;
      r_mem_wr_valid    <= 1'b0;
      r_d_valid         <= 1'b0;
      r_probe_ack_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hdr_fire) begin
            r_opcode <= c_opcode;
            r_hdr    <= w_c_hdr;
            if (w_hdr_misaligned) begin
              r_proto_err <= 1'b1;
            end
            case (c_opcode)
              TL_C_RELEASE_DATA, TL_C_PROBE_ACK_DATA: begin
                r_beat_cnt <= CNT_W'(1);
                r_state    <= S_COLLECT;
              end
              TL_C_RELEASE: begin
                r_d_valid <= 1'b1;
                r_state   <= S_ACK;
              end
              TL_C_PROBE_ACK: begin
                r_probe_ack_valid <= 1'b1;
                r_state           <= S_NOTIFY;
              end
              // Not a C-channel message we sink: swallow the beat and flag it.
              default: r_proto_err <= 1'b1;
            endcase
          end
        end
        S_COLLECT: begin
          if (w_collect_fire) begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            if (w_beat_mismatch) begin
              r_proto_err <= 1'b1;
            end
            if (r_beat_cnt == LAST_BEAT) begin
              r_mem_wr_valid <= 1'b1;
              r_state        <= S_MEM_WRITE;
            end
          end
        end
        S_MEM_WRITE: begin
          if (mem_wr_ready) begin
            r_mem_wr_valid <= 1'b0;
            if (r_opcode == TL_C_RELEASE_DATA) begin
              r_d_valid <= 1'b1;
              r_state   <= S_ACK;
            end else begin
              r_probe_ack_valid <= 1'b1;
              r_state           <= S_NOTIFY;
            end
          end
        end
        S_ACK: begin
          if (d_ready) begin
            r_d_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        S_NOTIFY: begin
          r_probe_ack_valid <= 1'b0;
          r_state           <= S_IDLE;
        end
        default: begin
          r_mem_wr_valid    <= 1'b0;
          r_d_valid         <= 1'b0;
          r_probe_ack_valid <= 1'b0;
          r_state           <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_wr_valid     = r_mem_wr_valid;
  assign mem_wr_addr      = r_hdr.address;
  assign mem_wr_data      = w_line;
  assign d_valid          = r_d_valid;
  assign d_opcode         = TL_D_RELEASE_ACK;
  assign d_param          = 3'd0;
  assign d_size           = r_hdr.size;
  assign d_source         = r_hdr.source;
  assign probe_ack_valid  = r_probe_ack_valid;
  assign probe_ack_param  = r_hdr.param;
  assign probe_ack_source = r_hdr.source;
  assign probe_ack_dirty  = (r_opcode == TL_C_PROBE_ACK_DATA);
  assign proto_err        = r_proto_err;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_tl_release_sink.sv
// Bench for tl_release_sink: directed steps plus randomized messages, checked against an
// ordered queue of expected mem-write / ReleaseAck / probe-ack events.
module tb_tl_release_sink;

  localparam int EV_W = 2 + 32 + 512;
  localparam logic [1:0] K_MEM = 2'd1;
  localparam logic [1:0] K_D   = 2'd2;
  localparam logic [1:0] K_PRB = 2'd3;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         c_valid = 1'b0;
  logic         c_ready;
  logic [2:0]   c_opcode = '0;
  logic [2:0]   c_param = '0;
  logic [3:0]   c_size = '0;
  logic [2:0]   c_source = '0;
  logic [31:0]  c_address = '0;
  logic [127:0] c_data = '0;
  logic         mem_wr_valid;
  logic         mem_wr_ready = 1'b0;
  logic [31:0]  mem_wr_addr;
  logic [511:0] mem_wr_data;
  logic         d_valid;
  logic         d_ready = 1'b0;
  logic [2:0]   d_opcode;
  logic [2:0]   d_param;
  logic [3:0]   d_size;
  logic [2:0]   d_source;
  logic         probe_ack_valid;
  logic [2:0]   probe_ack_param;
  logic [2:0]   probe_ack_source;
  logic         probe_ack_dirty;
  logic         proto_err;
  logic [2:0]   dbg_state;

  tl_release_sink dut (
    .clock(clock), .reset(reset),
    .c_valid(c_valid), .c_ready(c_ready), .c_opcode(c_opcode), .c_param(c_param),
    .c_size(c_size), .c_source(c_source), .c_address(c_address), .c_data(c_data),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source),
    .probe_ack_valid(probe_ack_valid), .probe_ack_param(probe_ack_param),
    .probe_ack_source(probe_ack_source), .probe_ack_dirty(probe_ack_dirty),
    .proto_err(proto_err), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [EV_W-1:0] exp_q[$];
  logic exp_perr = 1'b0;
  int   mem_delay = 0;
  int   d_delay = 0;
  int   max_gap = 0;
  logic lat_chk = 1'b0;
  int   hdr_cyc = 0;

  task automatic chk(input string tag, input logic [EV_W-1:0] got, input logic [EV_W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [EV_W-1:0] ev_mem(input logic [31:0] a, input logic [511:0] l);
    return {K_MEM, a, l};
  endfunction

  function automatic logic [EV_W-1:0] ev_d(input logic [2:0] op, input logic [2:0] prm,
                                           input logic [3:0] sz, input logic [2:0] src);
    logic [EV_W-1:0] e = '0;
    e[EV_W-1 -: 2] = K_D;
    e[12:0] = {op, prm, sz, src};
    return e;
  endfunction

  function automatic logic [EV_W-1:0] ev_prb(input logic [2:0] prm, input logic [2:0] src,
                                             input logic dirty);
    logic [EV_W-1:0] e = '0;
    e[EV_W-1 -: 2] = K_PRB;
    e[6:0] = {dirty, prm, src};
    return e;
  endfunction

  task automatic check_event(input string tag, input logic [EV_W-1:0] obs);
    logic [EV_W-1:0] e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk(tag, obs, e);
  endtask

  // Reference model: what a completed message must produce, in order.
  task automatic model(input logic [2:0] op, input logic [2:0] prm, input logic [2:0] src,
                       input logic [31:0] addr, input logic [511:0] line, input int bad_beat);
    if (addr[5:0] != 6'd0) exp_perr = 1'b1;
    case (op)
      3'd7: begin
        exp_q.push_back(ev_mem(addr, line));
        exp_q.push_back(ev_d(3'd6, 3'd0, 4'd6, src));
      end
      3'd5: begin
        exp_q.push_back(ev_mem(addr, line));
        exp_q.push_back(ev_prb(prm, src, 1'b1));
      end
      3'd6: exp_q.push_back(ev_d(3'd6, 3'd0, 4'd6, src));
      3'd4: exp_q.push_back(ev_prb(prm, src, 1'b0));
      default: exp_perr = 1'b1;
    endcase
    if ((op == 3'd5 || op == 3'd7) && bad_beat > 0 && bad_beat < 4) exp_perr = 1'b1;
  endtask

  // ---------------- responders for mem / D ready ----------------
  initial begin
    int mem_cnt = 0;
    int d_cnt = 0;
    forever begin
      @(posedge clock); #1;
      if (mem_wr_valid === 1'b1) begin
        mem_wr_ready = (mem_cnt >= mem_delay);
        mem_cnt++;
      end else begin
        mem_wr_ready = 1'b0;
        mem_cnt = 0;
      end
      if (d_valid === 1'b1) begin
        d_ready = (d_cnt >= d_delay);
        d_cnt++;
      end else begin
        d_ready = 1'b0;
        d_cnt = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic prev_mem_stall = 1'b0;
    logic prev_d_stall = 1'b0;
    logic prev_prb = 1'b0;
    logic prev_d_valid = 1'b0;
    int mem_hold = 0;
    int d_hold = 0;
    forever begin
      @(negedge clock);
      if (reset) chk("c_ready_in_reset", c_ready, 0);
      else if (mem_wr_valid || d_valid || probe_ack_valid) chk("c_ready_while_busy", c_ready, 0);
      if (prev_mem_stall) chk("mem_valid_held", mem_wr_valid, 1);
      if (prev_d_stall) chk("d_valid_held", d_valid, 1);
      if (probe_ack_valid) chk("probe_pulse_one_cycle", prev_prb, 0);
      mem_hold = mem_wr_valid ? mem_hold + 1 : 0;
      d_hold = d_valid ? d_hold + 1 : 0;
      if (d_valid && !prev_d_valid && lat_chk) begin
        chk("release_latency", cyc - hdr_cyc, 5);
        lat_chk = 1'b0;
      end
      if (mem_wr_valid && mem_wr_ready) begin
        chk("mem_hold_cycles", mem_hold, mem_delay + 1);
        check_event("mem_write", ev_mem(mem_wr_addr, mem_wr_data));
      end
      if (d_valid && d_ready) begin
        chk("d_hold_cycles", d_hold, d_delay + 1);
        check_event("release_ack", ev_d(d_opcode, d_param, d_size, d_source));
      end
      if (probe_ack_valid)
        check_event("probe_ack", ev_prb(probe_ack_param, probe_ack_source, probe_ack_dirty));
      prev_mem_stall = mem_wr_valid && !mem_wr_ready && !reset;
      prev_d_stall = d_valid && !d_ready && !reset;
      prev_prb = probe_ack_valid;
      prev_d_valid = d_valid;
    end
  end

  // ---------------- driver tasks (caller sits at posedge + 1) ----------------
  task automatic sync();
    @(posedge clock); #1;
  endtask

  task automatic send_beat(input logic [2:0] op, input logic [2:0] prm, input logic [2:0] src,
                           input logic [31:0] addr, input logic [127:0] data, input bit first);
    int waits = 0;
    c_valid = 1'b1; c_opcode = op; c_param = prm; c_size = 4'd6;
    c_source = src; c_address = addr; c_data = data;
    while (!c_ready && waits < 200) begin
      sync();
      waits++;
    end
    chk("c_ready_wait_bound", waits < 200, 1);
    if (first) hdr_cyc = cyc;
    sync();
  endtask

  task automatic send_msg(input logic [2:0] op, input logic [2:0] prm, input logic [2:0] src,
                          input logic [31:0] addr, input logic [511:0] line,
                          input int stop_after, input int bad_beat);
    int nb = (op == 3'd5 || op == 3'd7) ? 4 : 1;
    if (stop_after > 0) nb = stop_after;
    for (int b = 0; b < nb; b++) begin
      repeat ($urandom_range(0, max_gap)) begin
        c_valid = 1'b0;
        sync();
      end
      send_beat(op, prm, (b == bad_beat) ? (src ^ 3'd1) : src, addr, line[b*128 +: 128], b == 0);
    end
    c_valid = 1'b0;
    if (stop_after == 0) model(op, prm, src, addr, line, bad_beat);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (!(exp_q.size() == 0 && c_ready) && n < 200) begin
      sync();
      n++;
    end
    chk(tag, n < 200, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    c_valid = 1'b0;
    repeat (2) sync();
    chk("rst_mem_wr_valid", mem_wr_valid, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_probe_ack_valid", probe_ack_valid, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_c_ready", c_ready, 0);
    reset = 1'b0;
    exp_perr = 1'b0;
    sync();
    chk("c_ready_after_reset", c_ready, 1);
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [31:0] rand_addr();
    return $urandom & 32'hFFFF_FFC0;
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [511:0] line;
    do_reset();

    // 1: ReleaseData, back-to-back beats, immediate readies, latency check
    for (int k = 0; k < 4; k++) line[k*128 +: 128] = {4{32'hA0A0_0000 | k}};
    mem_delay = 0; d_delay = 0; max_gap = 0; lat_chk = 1'b1;
    send_msg(3'd7, 3'd0, 3'd2, 32'h8000_0040, line, 0, -1);
    drain("drain_release_data");
    chk("latency_checked", lat_chk, 0);
    chk("perr_after_release_data", proto_err, exp_perr);

    // 2: Release (no data), NtoN, D ready held off 3 cycles
    d_delay = 3;
    send_msg(3'd6, 3'd5, 3'd5, rand_addr(), '0, 0, -1);
    drain("drain_release");

    // 3: ProbeAckData TtoN with delayed write ready
    d_delay = 0; mem_delay = 2; max_gap = 1;
    send_msg(3'd5, 3'd1, 3'd1, rand_addr(), rand_line(), 0, -1);
    drain("drain_probe_ack_data");

    // 4: ProbeAck immediately followed by ReleaseData
    mem_delay = 0;
    send_msg(3'd4, 3'd2, 3'd3, rand_addr(), '0, 0, -1);
    send_msg(3'd7, 3'd0, 3'd4, rand_addr(), rand_line(), 0, -1);
    drain("drain_back_to_back");
    chk("perr_clean_traffic", proto_err, exp_perr);

    // 5: reset after three beats of a ReleaseData, then a normal Release
    send_msg(3'd7, 3'd0, 3'd6, rand_addr(), rand_line(), 3, -1);
    do_reset();
    repeat (8) sync();
    send_msg(3'd6, 3'd3, 3'd7, rand_addr(), '0, 0, -1);
    drain("drain_release_after_abort");
    chk("perr_after_abort", proto_err, exp_perr);

    // 6: protocol errors are sticky until reset and have no other effect
    send_msg(3'd2, 3'd0, 3'd1, rand_addr(), '0, 0, -1);
    drain("drain_bad_opcode");
    chk("perr_bad_opcode", proto_err, exp_perr);
    send_msg(3'd6, 3'd5, 3'd2, rand_addr(), '0, 0, -1);
    drain("drain_release_after_err");
    chk("perr_sticky", proto_err, exp_perr);
    do_reset();
    send_msg(3'd7, 3'd0, 3'd3, rand_addr(), rand_line(), 0, 3);
    drain("drain_bad_source_beat");
    chk("perr_beat3_source", proto_err, exp_perr);
    do_reset();
    send_msg(3'd6, 3'd5, 3'd2, 32'h8000_0044, '0, 0, -1);
    drain("drain_misaligned");
    chk("perr_misaligned", proto_err, exp_perr);
    do_reset();

    // 7: randomized legal traffic
    for (int i = 0; i < 24; i++) begin
      logic [2:0] op;
      op = 3'(4 + $urandom_range(0, 3));
      send_msg(op, 3'($urandom_range(0, 5)), 3'($urandom_range(0, 7)), rand_addr(),
               rand_line(), 0, -1);
      if ($urandom_range(0, 1) == 1) begin
        drain("drain_random");
        mem_delay = $urandom_range(0, 3);
        d_delay = $urandom_range(0, 3);
        max_gap = $urandom_range(0, 2);
      end
    end
    drain("drain_random_final");
    chk("perr_random_traffic", proto_err, exp_perr);
    chk("queue_empty_at_end", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
